generador_tono: RTL and testbench



---
 rtl/generador_tono.sv | 154 +++++++++++++++
 tb/tb_generador_tono.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/generador_tono.sv
// Square-wave note generator: plays a latched note for DUR_CYCLES, then a silent GAP_CYCLES gap.
// Optional octave-up select is enabled by defining GENERADOR_TONO_OCTAVA_EN.
module generador_tono #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned DUR_CYCLES = 12500000,
    parameter int unsigned GAP_CYCLES = 1250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] notaEntrada,
    input  logic       contar,
`ifdef GENERADOR_TONO_OCTAVA_EN
    input  logic       octava,
    output logic       octavaActual,
`endif
    output logic       audio,
    output logic       sonando,
    output logic [2:0] notaActual
);

    localparam int unsigned HP1 = CLK_HZ / (2 * 262);
    localparam int unsigned HP2 = CLK_HZ / (2 * 294);
    localparam int unsigned HP3 = CLK_HZ / (2 * 330);
    localparam int unsigned HP4 = CLK_HZ / (2 * 349);
    localparam int unsigned HP5 = CLK_HZ / (2 * 392);
    localparam int unsigned HP6 = CLK_HZ / (2 * 440);
    localparam int unsigned HP7 = CLK_HZ / (2 * 494);

    // HP1 is the longest half-period, so it sizes the phase counter.
    localparam int unsigned PW      = $clog2(HP1);
    localparam int unsigned CNT_MAX = (DUR_CYCLES > GAP_CYCLES) ? DUR_CYCLES : GAP_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DUR_LAST = CW'(DUR_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

    state_e          state_q;
    logic            contar_q;
    logic            audio_q;
    logic            sonando_q;
    logic [2:0]      nota_q;
    logic [PW-1:0]   phase_q;
    logic [CW-1:0]   cnt_q;
    logic            ev;
    logic [31:0]     hp_full;
    logic [PW-1:0]   hp_last;
`ifdef GENERADOR_TONO_OCTAVA_EN
    logic            octava_q;
`endif

    assign ev = contar & ~contar_q;

    always_comb begin
        hp_full = HP1;
        case (nota_q)
            3'd2:    hp_full = HP2;
            3'd3:    hp_full = HP3;
            3'd4:    hp_full = HP4;
            3'd5:    hp_full = HP5;
            3'd6:    hp_full = HP6;
            3'd7:    hp_full = HP7;
            default: hp_full = HP1;
        endcase
`ifdef GENERADOR_TONO_OCTAVA_EN
        if (octava_q) begin
            hp_full = hp_full >> 1;
        end
`endif
        hp_last = PW'(hp_full - 32'd1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            contar_q  <= 1'b0;
            audio_q   <= 1'b0;
            sonando_q <= 1'b0;
            nota_q    <= 3'd0;
            phase_q   <= '0;
            cnt_q     <= '0;
`ifdef GENERADOR_TONO_OCTAVA_EN
            octava_q  <= 1'b0;
`endif
        end else begin
            contar_q <= contar;
            // A play request overrides any counter expiry on the same cycle.
            if (ev) begin
                phase_q <= '0;
                cnt_q   <= '0;
                audio_q <= 1'b0;
                if (notaEntrada != 3'd0) begin
                    state_q   <= StPlay;
                    sonando_q <= 1'b1;
                    nota_q    <= notaEntrada;
`ifdef GENERADOR_TONO_OCTAVA_EN
                    octava_q  <= octava;
`endif
                end else begin
                    state_q   <= StIdle;
                    sonando_q <= 1'b0;
                    nota_q    <= 3'd0;
`ifdef GENERADOR_TONO_OCTAVA_EN
                    octava_q  <= 1'b0;
`endif
                end
            end else begin
                case (state_q)
                    StPlay: begin
                        if (cnt_q == DUR_LAST) begin
                            state_q <= StGap;
                            cnt_q   <= '0;
                            phase_q <= '0;
                            audio_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                            if (phase_q == hp_last) begin
                                phase_q <= '0;
                                audio_q <= ~audio_q;
                            end else begin
                                phase_q <= phase_q + 1'b1;
                            end
                        end
                    end
                    StGap: begin
                        if (cnt_q == GAP_LAST) begin
                            state_q   <= StIdle;
                            cnt_q     <= '0;
                            sonando_q <= 1'b0;
                            nota_q    <= 3'd0;
`ifdef GENERADOR_TONO_OCTAVA_EN
                            octava_q  <= 1'b0;
`endif
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign audio      = audio_q;
    assign sonando    = sonando_q;
    assign notaActual = nota_q;
`ifdef GENERADOR_TONO_OCTAVA_EN
    assign octavaActual = octava_q;
`endif

endmodule

// File: tb/tb_generador_tono.sv
// Directed bench for generador_tono at CLK_HZ=52400, DUR_CYCLES=1000, GAP_CYCLES=50.
module tb_generador_tono;

    logic       clk;
    logic       reset;
    logic [2:0] notaEntrada;
    logic       contar;
    logic       audio;
    logic       sonando;
    logic [2:0] notaActual;
`ifdef GENERADOR_TONO_OCTAVA_EN
    logic       octava;
    logic       octavaActual;
`endif

    int checks = 0;
    int errors = 0;

    generador_tono #(
        .CLK_HZ     (52400),
        .DUR_CYCLES (1000),
        .GAP_CYCLES (50)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .notaEntrada  (notaEntrada),
        .contar       (contar),
`ifdef GENERADOR_TONO_OCTAVA_EN
        .octava       (octava),
        .octavaActual (octavaActual),
`endif
        .audio        (audio),
        .sonando      (sonando),
        .notaActual   (notaActual)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle play pulse; returns one step after the sampling edge (cycle 0 of the note).
    task automatic start_note(input logic [2:0] n);
        contar      = 1'b1;
        notaEntrada = n;
        step(1);
        contar      = 1'b0;
    endtask

    task automatic measure(input int ncyc, output int first_rise, output int rises,
                           output int period, output int last_high, output int son_off,
                           output int son_reon);
        logic prev;
        int   second_rise;
        first_rise  = -1;
        second_rise = -1;
        rises       = 0;
        last_high   = -1;
        son_off     = -1;
        son_reon    = 0;
        prev        = audio;
        for (int k = 1; k <= ncyc; k++) begin
            step(1);
            if (audio && !prev) begin
                rises++;
                if (first_rise < 0) first_rise = k;
                else if (second_rise < 0) second_rise = k;
            end
            if (audio) last_high = k;
            if (!sonando && son_off < 0) son_off = k;
            if (sonando && son_off >= 0) son_reon = 1;
            prev = audio;
        end
        period = (second_rise >= 0) ? second_rise - first_rise : -1;
    endtask

    int fr, rs, per, lh, so, sr;
    int bad;

    initial begin
        reset       = 1'b0;
        contar      = 1'b0;
        notaEntrada = 3'd0;
`ifdef GENERADOR_TONO_OCTAVA_EN
        octava      = 1'b0;
`endif
        // Reset hold and quiet idle
        step(5);
        check_eq("rst_audio", int'(audio), 0);
        check_eq("rst_sonando", int'(sonando), 0);
        check_eq("rst_nota", int'(notaActual), 0);
        reset       = 1'b1;
        notaEntrada = 3'd3;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (audio || sonando || notaActual != 3'd0) bad++;
        end
        check_eq("idle_quiet", bad, 0);

        // Note 1, single pulse: HP=100
        start_note(3'd1);
        check_eq("n1_sonando", int'(sonando), 1);
        check_eq("n1_nota", int'(notaActual), 1);
        check_eq("n1_audio0", int'(audio), 0);
        measure(1100, fr, rs, per, lh, so, sr);
        check_eq("n1_first_rise", fr, 100);
        check_eq("n1_period", per, 200);
        check_eq("n1_rises", rs, 5);
        check_eq("n1_last_high", lh, 999);
        check_eq("n1_son_off", so, 1050);
        check_eq("n1_nota_idle", int'(notaActual), 0);

        // Note 6 with contar held high: HP=59, one note only
        contar      = 1'b1;
        notaEntrada = 3'd6;
        step(1);
        check_eq("n6_nota", int'(notaActual), 6);
        measure(3000, fr, rs, per, lh, so, sr);
        check_eq("n6_first_rise", fr, 59);
        check_eq("n6_period", per, 118);
        check_eq("n6_rises", rs, 8);
        check_eq("n6_last_high", lh, 943);
        check_eq("n6_son_off", so, 1050);
        check_eq("n6_single", sr, 0);
        contar = 1'b0;
        step(2);

        // Retrigger note 1 -> note 3 at PLAY cycle 500
        start_note(3'd1);
        step(499);
        start_note(3'd3);
        check_eq("rt_nota", int'(notaActual), 3);
        check_eq("rt_audio0", int'(audio), 0);
        check_eq("rt_sonando", int'(sonando), 1);
        measure(1100, fr, rs, per, lh, so, sr);
        check_eq("rt_first_rise", fr, 79);
        check_eq("rt_period", per, 158);
        check_eq("rt_rises", rs, 6);
        check_eq("rt_son_off", so, 1050);

        // Stop note 2 with a silence request at cycle 300
        start_note(3'd2);
        step(299);
        check_eq("stop_audio_hi", int'(audio), 1);
        start_note(3'd0);
        check_eq("stop_sonando", int'(sonando), 0);
        check_eq("stop_nota", int'(notaActual), 0);
        check_eq("stop_audio", int'(audio), 0);
        step(5);

        // Asynchronous reset mid-note, release with contar already high
        start_note(3'd1);
        step(150);
        check_eq("ar_audio_hi", int'(audio), 1);
        #2 reset = 1'b0;
        #1;
        check_eq("ar_audio", int'(audio), 0);
        check_eq("ar_sonando", int'(sonando), 0);
        check_eq("ar_nota", int'(notaActual), 0);
        contar      = 1'b1;
        notaEntrada = 3'd5;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        step(1);
        check_eq("rel_sonando", int'(sonando), 1);
        check_eq("rel_nota", int'(notaActual), 5);
        check_eq("rel_audio", int'(audio), 0);
        contar = 1'b0;
        measure(1100, fr, rs, per, lh, so, sr);
        check_eq("rel_first_rise", fr, 66);
        check_eq("rel_son_off", so, 1050);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
